// File: rtl/mcu_bus_pkg.sv
// ---------------------------------------------------------------------------
// mcu_bus_pkg
// Shared definitions for the MCU register bus event logic.
//   NREG_DEFAULT  : default number of bus registers
//   DEPTH_DEFAULT : default event FIFO depth (power of two, >= 2)
//   evt_t         : one queued event, {register address, register data}
//   EVT_W         : flat bit width of evt_t, used on simple-typed ports
// ---------------------------------------------------------------------------
package mcu_bus_pkg;

  localparam int NREG_DEFAULT  = 16;
  localparam int DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

endpackage : mcu_bus_pkg

// File: rtl/mcu_reg_event_fifo_evt_fifo.sv
// ---------------------------------------------------------------------------
// evt_fifo
// Synchronous event FIFO. Writes are requested with push, and reads use a
// valid/ready handshake on the head entry.
//   CLK50      : clock, rising edge
//   rst_n      : asynchronous active-low reset (pointers and count)
//   push       : write push_data this cycle (dropped when full without pop)
//   push_data  : entry to store, flat evt_t
//   full       : FIFO holds DEPTH entries
//   evt_valid  : head entry valid (count != 0)
//   evt_ready  : consumer accepts the head entry
//   head       : head entry, flat evt_t
//   count      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module evt_fifo
  import mcu_bus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     CLK50,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [EVT_W-1:0]         push_data,
  output logic                     full,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [EVT_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             pop;
  logic             wr_en;

  assign evt_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = evt_valid & evt_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle;
  // the write lands in the slot the head is vacating.
  assign wr_en     = push & (~full | pop);
  assign head      = mem[rptr];

  // Storage carries no reset; evt_valid alone qualifies what it holds.
  always_ff @(posedge CLK50) begin
    if (wr_en) begin
      mem[wptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : evt_fifo

// File: rtl/mcu_reg_event_fifo.sv
// ---------------------------------------------------------------------------
// mcu_reg_event_fifo
// Watches the MCU-written bus registers and queues one {addr, data} event per
// register write or written-data change. Detected events are held in a
// pending mask. The lowest pending address is pushed into an event FIFO,
// one per cycle. While the FIFO is full, events stay pending and are not
// lost. A repeat event on an address that is already pending is merged with
// the earlier one and sets the sticky coalesce_err flag.
//   CLK50        : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   reg_data_out : NREG x 8-bit register contents, register a at [a*8 +: 8]
//   write_read   : per-register last-access flag (1 = write)
//   evt_valid    : FIFO head valid
//   evt_ready    : consumer accepts head
//   evt_addr     : head register address
//   evt_data     : head register data
//   fifo_count   : FIFO occupancy
//   coalesce_err : sticky, an event merged into an already-pending one
//   err_clr      : synchronous clear of coalesce_err (wins over a set)
// ---------------------------------------------------------------------------
module mcu_reg_event_fifo
  import mcu_bus_pkg::*;
#(
  parameter int NREG  = NREG_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     CLK50,
  input  logic                     rst_n,
  input  logic [NREG*8-1:0]        reg_data_out,
  input  logic [NREG-1:0]          write_read,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [3:0]               evt_addr,
  output logic [7:0]               evt_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     coalesce_err,
  input  logic                     err_clr
);

  logic [NREG*8-1:0] shadow_data;
  logic [NREG-1:0]   shadow_wr;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   detect;
  logic [NREG-1:0]   grant;
  logic [NREG-1:0]   push_mask;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              coalesce_hit;
  evt_t              push_evt;
  evt_t              head_evt;
  logic [EVT_W-1:0]  push_bits;
  logic [EVT_W-1:0]  head_bits;

  // An address fires on a 0->1 write flag, or when it is still flagged as
  // written and its data moved. Read-flagged registers never fire.
  always_comb begin
    detect = '0;
    for (int a = 0; a < NREG; a++) begin
      detect[a] = write_read[a] &
                  (~shadow_wr[a] | (reg_data_out[a*8 +: 8] != shadow_data[a*8 +: 8]));
    end
  end

  // Isolate the lowest set pending bit (two's-complement trick).
  assign grant = pending & (~pending + {{(NREG-1){1'b0}}, 1'b1});

  // Data is taken from the live register, so the entry holds the newest value
  // even after the address waited on backpressure.
  always_comb begin
    push_evt = '0;
    for (int i = 0; i < NREG; i++) begin
      if (grant[i]) begin
        push_evt.addr = 4'(i);
        push_evt.data = reg_data_out[i*8 +: 8];
      end
    end
  end

  assign pop          = evt_valid & evt_ready;
  assign push         = (|pending) & (~fifo_full | pop);
  assign push_mask    = push ? grant : '0;
  // A detect on the address that is being pushed re-arms it. This is not a
  // merge, so only pending bits that stay put count as coalesced.
  assign coalesce_hit = |(detect & pending & ~push_mask);

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data  <= '0;
      shadow_wr    <= '0;
      pending      <= '0;
      coalesce_err <= 1'b0;
    end else begin
      shadow_data <= reg_data_out;
      shadow_wr   <= write_read;
      pending     <= (pending & ~push_mask) | detect;
      if (err_clr) begin
        coalesce_err <= 1'b0;
      end else if (coalesce_hit) begin
        coalesce_err <= 1'b1;
      end
    end
  end

  assign push_bits = push_evt;

  evt_fifo #(
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .CLK50     (CLK50),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_bits),
    .full      (fifo_full),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .head      (head_bits),
    .count     (fifo_count)
  );

  assign head_evt = head_bits;
  assign evt_addr = head_evt.addr;
  assign evt_data = head_evt.data;

endmodule : mcu_reg_event_fifo

// File: tb/tb_mcu_reg_event_fifo.sv
// ---------------------------------------------------------------------------
// tb_mcu_reg_event_fifo
// Directed bench for mcu_reg_event_fifo with NREG=16, DEPTH=8. Inputs change
// and outputs are checked 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mcu_reg_event_fifo;

  logic        CLK50 = 1'b0;
  logic        rst_n;
  logic [7:0]  regs [16];
  logic [127:0] reg_data_out;
  logic [15:0] write_read;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_addr;
  logic [7:0]  evt_data;
  logic [3:0]  fifo_count;
  logic        coalesce_err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  always #5 CLK50 = ~CLK50;

  always_comb begin
    reg_data_out = '0;
    for (int i = 0; i < 16; i++) begin
      reg_data_out[i*8 +: 8] = regs[i];
    end
  end

  mcu_reg_event_fifo #(
    .NREG  (16),
    .DEPTH (8)
  ) dut (
    .CLK50        (CLK50),
    .rst_n        (rst_n),
    .reg_data_out (reg_data_out),
    .write_read   (write_read),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_addr     (evt_addr),
    .evt_data     (evt_data),
    .fifo_count   (fifo_count),
    .coalesce_err (coalesce_err),
    .err_clr      (err_clr)
  );

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge CLK50);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int exp3 [9];
    int exp4 [9];
    exp3 = '{0, 1, 4, 5, 6, 8, 9, 10, 11};
    exp4 = '{0, 1, 5, 6, 8, 9, 10, 11, 4};

    rst_n      = 1'b0;
    evt_ready  = 1'b0;
    err_clr    = 1'b0;
    write_read = '0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    #2;
    checkOutput("rst_valid", evt_valid, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_err", coalesce_err, 0);
    @(posedge CLK50);
    #1;
    rst_n = 1'b1;
    applyStimulus(2);
    checkOutput("idle_valid", evt_valid, 0);

    // Single write, two-cycle latency, immediate pop.
    $display("[TB] single write reg 3");
    evt_ready     = 1'b1;
    regs[3]       = 8'h5A;
    write_read[3] = 1'b1;
    applyStimulus(1);
    checkOutput("t1_n1_valid", evt_valid, 0);
    applyStimulus(1);
    checkOutput("t1_valid", evt_valid, 1);
    checkOutput("t1_addr", evt_addr, 3);
    checkOutput("t1_data", evt_data, 8'h5A);
    checkOutput("t1_count", fifo_count, 1);
    applyStimulus(1);
    checkOutput("t1_popped_count", fifo_count, 0);
    checkOutput("t1_popped_valid", evt_valid, 0);

    // Two writes in one cycle: lowest address first.
    $display("[TB] simultaneous regs 7 and 2");
    regs[7] = 8'h77; write_read[7] = 1'b1;
    regs[2] = 8'h22; write_read[2] = 1'b1;
    applyStimulus(2);
    checkOutput("t2_first_addr", evt_addr, 2);
    checkOutput("t2_first_data", evt_data, 8'h22);
    applyStimulus(1);
    checkOutput("t2_second_valid", evt_valid, 1);
    checkOutput("t2_second_addr", evt_addr, 7);
    checkOutput("t2_second_data", evt_data, 8'h77);
    applyStimulus(1);
    checkOutput("t2_empty", fifo_count, 0);

    // Nine addresses with ready low: eight queued, ninth held pending.
    $display("[TB] backpressure with nine addresses");
    evt_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      regs[exp3[k]]       = 8'(8'h30 + exp3[k]);
      write_read[exp3[k]] = 1'b1;
    end
    applyStimulus(9);
    checkOutput("t3_full_count", fifo_count, 8);
    checkOutput("t3_head_addr", evt_addr, 0);
    applyStimulus(2);
    checkOutput("t3_hold_count", fifo_count, 8);
    evt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("t3_valid_%0d", k), evt_valid, 1);
      checkOutput($sformatf("t3_addr_%0d", k), evt_addr, exp3[k]);
      checkOutput($sformatf("t3_data_%0d", k), evt_data, 8'h30 + exp3[k]);
      applyStimulus(1);
    end
    checkOutput("t3_drained", fifo_count, 0);
    checkOutput("t3_no_err", coalesce_err, 0);

    // Full FIFO, reg 4 changes twice while pending: merged, error flagged.
    $display("[TB] coalesce on reg 4");
    evt_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      regs[exp4[k]] = 8'(8'h40 + exp4[k]);
    end
    applyStimulus(9);
    checkOutput("t4_full", fifo_count, 8);
    checkOutput("t4_err_before", coalesce_err, 0);
    regs[4] = 8'h11;
    applyStimulus(1);
    regs[4] = 8'h22;
    applyStimulus(1);
    checkOutput("t4_err_set", coalesce_err, 1);
    checkOutput("t4_still_full", fifo_count, 8);
    evt_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("t4_addr_%0d", k), evt_addr, exp4[k]);
      checkOutput($sformatf("t4_data_%0d", k), evt_data,
                  (k == 8) ? 32'h22 : 32'h40 + exp4[k]);
      applyStimulus(1);
    end
    checkOutput("t4_drained", fifo_count, 0);
    checkOutput("t4_err_sticky", coalesce_err, 1);
    err_clr = 1'b1;
    applyStimulus(1);
    err_clr = 1'b0;
    checkOutput("t4_err_cleared", coalesce_err, 0);

    // Read-flagged register ignores data changes until written again.
    $display("[TB] read then write reg 1");
    write_read[1] = 1'b0;
    applyStimulus(3);
    checkOutput("t5_read_quiet", evt_valid, 0);
    regs[1] = 8'h99;
    applyStimulus(3);
    checkOutput("t5_change_quiet", evt_valid, 0);
    regs[1]       = 8'h80;
    write_read[1] = 1'b1;
    applyStimulus(2);
    checkOutput("t5_valid", evt_valid, 1);
    checkOutput("t5_addr", evt_addr, 1);
    checkOutput("t5_data", evt_data, 8'h80);
    applyStimulus(1);
    checkOutput("t5_popped", fifo_count, 0);

    // Mid-operation reset, then flags already at 1 fire again.
    $display("[TB] reset with five queued");
    evt_ready = 1'b0;
    for (int a = 5; a <= 10; a++) begin
      if (a != 7) regs[a] = 8'(8'h50 + a);
    end
    applyStimulus(6);
    checkOutput("t6_count5", fifo_count, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", evt_valid, 0);
    checkOutput("t6_rst_count", fifo_count, 0);
    @(posedge CLK50);
    #1;
    rst_n = 1'b1;
    applyStimulus(2);
    checkOutput("t6_rel_count", fifo_count, 1);
    evt_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("t6_addr_%0d", k), evt_addr, k);
      checkOutput($sformatf("t6_data_%0d", k), evt_data, regs[k]);
      applyStimulus(1);
    end
    checkOutput("t6_drained", fifo_count, 0);
    checkOutput("t6_no_err", coalesce_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mcu_reg_event_fifo
